poly_addsub_lanes: RTL and testbench
====================================

# poly_addsub_lanes

Parametrised, two-stage pipelined modular add/subtract unit for packed polynomial coefficient streams. Processes `LANES` coefficients of `W` bits per beat modulo `Q`, with per-beat add/sub selection, a per-burst output beat index and an end-of-burst pulse. It sits between coefficient memories and the NTT and sampler datapaths, serving any modulus that fits in `W` bits.

## Interface
- `LANES`, default 2: coefficients per beat.
- `W`, default 25: coefficient width; `Q < 2^W` required.
- `Q`, default 33292289: modulus, `W` bits.
- `CNT_W`, default 8: width of the output beat index.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_flag` input 1: input beat valid.
- `sub` input 1: 1 = `din1 - din2`, 0 = `din1 + din2`; sampled with the beat.
- `din1`, `din2` input `LANES*W`: packed operands; lane i at `[i*W +: W]`; lane `LANES-1` in the MSBs.
- `dout` output `LANES*W`: packed results, same lane layout.
- `out_flag` output 1: `dout` valid.
- `out_idx` output `CNT_W`: index of the current output beat within its burst.
- `out_rst` output 1: end-of-burst pulse; combinational.

## Operation
- **Burst:** a maximal run of consecutive cycles with `in_flag` = 1.
- **Stage 1, when `in_flag` = 1:**
  - Per lane, compute `t_i` (W+1 bits, two's complement, modulo 2^(W+1)): `a+b-Q` for add, `a-b` for sub.
  - Register `v1` <= 1.
  - When `in_flag` = 0: clear all `t_i` and `v1` to 0.
- **Stage 2, when `v1` = 1:**
  - `dout` lane i <= `t_i[W-1:0] + (t_i[W] ? Q : 0)`, truncated to W bits.
  - `out_flag` <= 1.
  - When `v1` = 0: `dout` <= 0, `out_flag` <= 0.
- **Input range:** results are correct for inputs in [0, Q). Outputs for out-of-range inputs are deterministic per the formulas above; no correctness check applies to them.
- **Sub mode:** `sub` is pipelined with its beat. Mixing add and sub beats inside one burst is legal.
- **Beat index:** `out_idx` is 0 on the first output beat of a burst and increments by 1 on each following output beat. It wraps modulo 2^CNT_W. It returns to 0 on the cycle after `out_flag` falls and holds 0 while idle.
- **End-of-burst:** `out_rst = out_flag & ~v1`. It is high exactly on the final output beat of each burst.
- **Reset:** while `rst` = 1, all registers are cleared at the next edge regardless of `in_flag`. Beats in flight are discarded; no `out_rst` is generated for an aborted burst.

## Timing
- Latency: 2 cycles. A beat presented at edge n produces `dout`/`out_flag` after edge n+2.
- Throughput: 1 beat per cycle; no stall or backpressure.
- Reset values:
  - `dout` = 0, `out_flag` = 0, `out_idx` = 0.
  - `out_rst` = 0, because `out_flag` = 0.
- One-beat burst: `out_flag` is high for 1 cycle with `out_idx` = 0 and `out_rst` = 1 in the same cycle.
- Bursts separated by a single idle cycle produce two distinct `out_rst` pulses. `out_idx` restarts at 0 for the second burst.
- `rst` and `in_flag` high together: reset wins.

## Configuration
- `POLY_ADDSUB_SUB_EN` defined: subtraction path present; `sub` selects the operation per beat.
- Not defined:
  - `sub` is ignored and stage 1 always computes `a+b-Q`.
  - The `sub` port remains in the port list, so the port list is unchanged.

## Test plan
- Defaults, add: lane1 = 33292288 + 1, lane0 = 5 + 7 -> `dout` lane1 = 0, lane0 = 12, 2 cycles after input.
- Sub with `POLY_ADDSUB_SUB_EN`: lane0 = 3 - 5 -> 33292287; lane1 = 10 - 10 -> 0. Without the macro, the same stimulus -> lane0 = 8, lane1 = 20.
- 4-beat burst:
  - `out_flag` is high for 4 cycles with `out_idx` 0, 1, 2, 3.
  - `out_rst` is high only when `out_idx` = 3.
  - `dout` = 0 in idle cycles.
- Back-to-back bursts of 2 and 3 beats with 1 idle cycle between -> `out_rst` pulses on the 2nd and 5th output beats; `out_idx` sequence 0, 1, then 0, 1, 2.
- `rst` asserted on the 3rd cycle of a 6-beat burst:
  - All outputs are 0 on the next cycle, with no `out_rst` pulse.
  - After release with `in_flag` low, `out_flag` stays 0.
- `CNT_W` = 2, 6-beat burst -> `out_idx` 0, 1, 2, 3, 0, 1, with `out_rst` on the final beat only.

Source files
------------

// File: rtl/poly_addsub_lanes.sv
// Two-stage pipelined modular add/sub over LANES packed W-bit coefficients.
// Optional macro POLY_ADDSUB_SUB_EN enables the per-beat subtraction path.
module poly_addsub_lanes #(
    parameter int          LANES = 2,
    parameter int          W     = 25,
    parameter int unsigned Q     = 33292289,
    parameter int          CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_flag,
    input  logic                 sub,
    input  logic [LANES*W-1:0]   din1,
    input  logic [LANES*W-1:0]   din2,
    output logic [LANES*W-1:0]   dout,
    output logic                 out_flag,
    output logic [CNT_W-1:0]     out_idx,
    output logic                 out_rst
);

    localparam logic [W:0]   Q_X = (W+1)'(Q);
    localparam logic [W-1:0] Q_W = W'(Q);

    logic [W:0]         w_t [LANES];
    logic [LANES*W-1:0] w_res;

    logic [W:0]         r_t [LANES];
    logic               r_v1;
    logic [LANES*W-1:0] r_dout;
    logic               r_out_flag;
    logic [CNT_W-1:0]   r_idx;

    genvar g;
    for (g = 0; g < LANES; g++) begin : g_lane
        logic [W:0] w_a;
        logic [W:0] w_b;
        assign w_a = {1'b0, din1[g*W +: W]};
        assign w_b = {1'b0, din2[g*W +: W]};
`ifdef POLY_ADDSUB_SUB_EN
        assign w_t[g] = sub ? (w_a - w_b) : (w_a + w_b - Q_X);
`else
        assign w_t[g] = w_a + w_b - Q_X;
`endif
        // A negative stage-1 result (sign bit set) is folded back by adding Q.
        assign w_res[g*W +: W] = r_t[g][W-1:0] + (r_t[g][W] ? Q_W : '0);
    end

`ifndef POLY_ADDSUB_SUB_EN
    logic w_unused_sub;
    assign w_unused_sub = sub;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) begin
                r_t[i] <= '0;
            end
            r_v1       <= 1'b0;
            r_dout     <= '0;
            r_out_flag <= 1'b0;
            r_idx      <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                r_t[i] <= in_flag ? w_t[i] : '0;
            end
            r_v1       <= in_flag;
            r_dout     <= r_v1 ? w_res : '0;
            r_out_flag <= r_v1;
            // Index counts only while the output run is unbroken.
            r_idx      <= (r_v1 && r_out_flag) ? r_idx + CNT_W'(1) : '0;
        end
    end

    assign dout     = r_dout;
    assign out_flag = r_out_flag;
    assign out_idx  = r_idx;
    assign out_rst  = r_out_flag & ~r_v1;

endmodule

// File: tb/tb_poly_addsub_lanes.sv
// Scoreboard bench for poly_addsub_lanes: default instance plus a CNT_W=2 instance on shared stimulus.
module tb_poly_addsub_lanes;

    localparam int          LANES = 2;
    localparam int          W     = 25;
    localparam int unsigned Q     = 33292289;
    localparam int          CNT_W = 8;
    localparam int          DW    = LANES * W;
    localparam int          EW    = 1 + CNT_W + DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_flag;
    logic              sub;
    logic [DW-1:0]     din1;
    logic [DW-1:0]     din2;
    logic [DW-1:0]     dout;
    logic              out_flag;
    logic [CNT_W-1:0]  out_idx;
    logic              out_rst;
    logic [DW-1:0]     dout2;
    logic              out_flag2;
    logic [1:0]        out_idx2;
    logic              out_rst2;

    int checks   = 0;
    int failures = 0;
    logic mon_en = 1'b0;
    int drv_idx  = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp2_q[$];
    logic [EW-1:0] e1;
    logic [EW-1:0] e2;

    poly_addsub_lanes #(.LANES(LANES), .W(W), .Q(Q), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst(rst), .in_flag(in_flag), .sub(sub),
        .din1(din1), .din2(din2), .dout(dout),
        .out_flag(out_flag), .out_idx(out_idx), .out_rst(out_rst)
    );

    poly_addsub_lanes #(.LANES(LANES), .W(W), .Q(Q), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_flag(in_flag), .sub(sub),
        .din1(din1), .din2(din2), .dout(dout2),
        .out_flag(out_flag2), .out_idx(out_idx2), .out_rst(out_rst2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic beat(input int unsigned a1, input int unsigned b1,
                        input int unsigned a0, input int unsigned b0,
                        input logic s, input int unsigned x1, input int unsigned x0,
                        input logic last);
        logic [EW-1:0] e;
        in_flag = 1'b1;
        sub     = s;
        din1    = {W'(a1), W'(a0)};
        din2    = {W'(b1), W'(b0)};
        e = {last, CNT_W'(drv_idx), W'(x1), W'(x0)};
        exp_q.push_back(e);
        exp2_q.push_back(e);
        drv_idx = last ? 0 : drv_idx + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_flag = 1'b0;
        sub     = 1'b0;
        din1    = '0;
        din2    = '0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_flag) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e1 = exp_q.pop_front();
                    chk("dout", 64'(dout), 64'(e1[DW-1:0]));
                    chk("out_idx", 64'(out_idx), 64'(e1[DW +: CNT_W]));
                    chk("out_rst", 64'(out_rst), 64'(e1[EW-1]));
                end
            end else begin
                chk("idle_dout", 64'(dout), 64'd0);
                chk("idle_idx", 64'(out_idx), 64'd0);
                chk("idle_rst", 64'(out_rst), 64'd0);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_flag2) begin
                if (exp2_q.size() == 0) begin
                    chk("unexpected_beat2", 64'(exp2_q.size()), 64'd1);
                end else begin
                    e2 = exp2_q.pop_front();
                    chk("dout2", 64'(dout2), 64'(e2[DW-1:0]));
                    chk("out_idx2", 64'(out_idx2), 64'(e2[DW +: 2]));
                    chk("out_rst2", 64'(out_rst2), 64'(e2[EW-1]));
                end
            end else begin
                chk("idle_dout2", 64'(dout2), 64'd0);
                chk("idle_idx2", 64'(out_idx2), 64'd0);
                chk("idle_rst2", 64'(out_rst2), 64'd0);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        in_flag = 1'b0;
        sub     = 1'b0;
        din1    = '0;
        din2    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Single-beat add burst.
        beat(33292288, 1, 5, 7, 1'b0, 0, 12, 1'b1);
        idle(3);

        // Single-beat subtraction (add when the sub path is compiled out).
`ifdef POLY_ADDSUB_SUB_EN
        beat(10, 10, 3, 5, 1'b1, 0, 33292287, 1'b1);
`else
        beat(10, 10, 3, 5, 1'b1, 20, 8, 1'b1);
`endif
        idle(3);

        // Four-beat add burst.
        beat(100, 200, 33292288, 33292288, 1'b0, 300, 33292287, 1'b0);
        beat(0, 0, 1, 33292288, 1'b0, 0, 0, 1'b0);
        beat(16646144, 16646145, 16646144, 16646144, 1'b0, 0, 33292288, 1'b0);
        beat(12345, 54321, 33000000, 1000000, 1'b0, 66666, 707711, 1'b1);
        idle(3);

        // Bursts of 2 and 3 beats with one idle cycle between; mixed add/sub.
        beat(1, 2, 7, 8, 1'b0, 3, 15, 1'b0);
`ifdef POLY_ADDSUB_SUB_EN
        beat(50, 20, 0, 1, 1'b1, 30, 33292288, 1'b1);
`else
        beat(50, 20, 0, 1, 1'b1, 70, 1, 1'b1);
`endif
        idle(1);
        beat(9, 9, 40, 2, 1'b0, 18, 42, 1'b0);
        beat(33292288, 2, 2, 3, 1'b0, 1, 5, 1'b0);
        beat(11, 22, 44, 55, 1'b0, 33, 99, 1'b1);
        idle(3);

        // Reset on the third cycle of a six-beat burst; in-flight beats are dropped.
        beat(1, 1, 2, 2, 1'b0, 2, 4, 1'b0);
        beat(3, 3, 4, 4, 1'b0, 6, 8, 1'b0);
        in_flag = 1'b1;
        rst     = 1'b1;
        din1    = {W'(5), W'(6)};
        din2    = {W'(5), W'(6)};
        @(posedge clk);
        #1;
        rst     = 1'b0;
        in_flag = 1'b0;
        exp_q.delete();
        exp2_q.delete();
        drv_idx = 0;
        idle(4);

        // Six-beat burst: the CNT_W=2 instance wraps its index.
        for (int i = 1; i <= 6; i++) begin
            beat(i, i, i, i + 1, 1'b0, 2 * i, 2 * i + 1, i == 6);
        end
        idle(6);

        chk("q_drain", 64'(exp_q.size()), 64'd0);
        chk("q2_drain", 64'(exp2_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
